// File: rtl/hdmi_scan_ctrl.sv
// ---------------------------------------------------------------------------
// hdmi_scan_ctrl
//
// Scan-out scheduler for the HDMI video path. It generates horizontal and
// vertical raster timing, buffers upstream pixels in a small FIFO, and drives
// registered pixel, data-enable and sync outputs to the HDMI transmitter.
//
// Ports
//   clk           : pixel clock (single clock domain)
//   rst           : asynchronous active-low reset
//   enable        : permission to scan (tied to IIC configuration-done)
//   pix_in        : upstream pixel {r, g, b}
//   pix_valid     : pix_in is valid
//   pix_rdy       : FIFO accepts a pixel this cycle
//   out_data      : registered pixel to the transmitter
//   out_de        : registered data enable
//   out_hsync     : registered horizontal sync (asserted level = SYNC_POL)
//   out_vsync     : registered vertical sync (asserted level = SYNC_POL)
//   frame_start   : one-cycle pulse alongside pixel (0,0)
//   underflow     : sticky flag, an active pixel was due with an empty FIFO
//   underflow_clr : synchronous clear of underflow (a same-cycle set wins)
// ---------------------------------------------------------------------------
module hdmi_scan_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int FIFO_DEPTH = 16,
  parameter int PREFILL    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] pix_in,
  input  logic        pix_valid,
  output logic        pix_rdy,
  output logic [23:0] out_data,
  output logic        out_de,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One spare count value so the sync-end boundaries always fit.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] C_FULL     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_PREFILL  = CW'(PREFILL);
  localparam logic          SYNC_ON    = (SYNC_POL != 0);
  localparam logic          SYNC_OFF   = ~SYNC_ON;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_RUN
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [HW-1:0]   r_hCnt;
  logic [VW-1:0]   r_vCnt;
  logic            r_stop;
  logic [23:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;

  logic w_run;
  logic w_de;
  logic w_hsAct;
  logic w_vsAct;
  logic w_lastPix;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_flush;

  assign w_run     = (r_state == ST_RUN);
  assign w_de      = (r_hCnt < H_ACT) && (r_vCnt < V_ACT);
  assign w_hsAct   = (r_hCnt >= H_SYNC_BEG) && (r_hCnt < H_SYNC_END);
  assign w_vsAct   = (r_vCnt >= V_SYNC_BEG) && (r_vCnt < V_SYNC_END);
  assign w_lastPix = (r_hCnt == H_LAST) && (r_vCnt == V_LAST);
  assign w_full    = (r_count == C_FULL);
  assign w_empty   = (r_count == '0);
  assign w_push    = pix_valid && pix_rdy;
  // No bypass: a pixel pushed into an empty FIFO is popped one cycle later.
  assign w_pop     = w_run && w_de && !w_empty;
  // Every transition into (or stay in) IDLE empties the FIFO.
  assign w_flush   = (w_stateNext == ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and ready logic. A stop request in RUN only takes effect on
  // the last raster position so a frame is never cut short.
  always_comb begin
    w_stateNext = r_state;
    pix_rdy     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_stateNext = ST_PREFILL;
        end
      end
      ST_PREFILL: begin
        pix_rdy = !w_full;
        if (!enable) begin
          w_stateNext = ST_IDLE;
        end else if (r_count >= C_PREFILL) begin
          w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        pix_rdy = !w_full;
        if (w_lastPix && (r_stop || !enable)) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Stop latch: remembers that enable dropped at any point during RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stop <= 1'b0;
    end else if (!w_run) begin
      r_stop <= 1'b0;
    end else if (!enable) begin
      r_stop <= 1'b1;
    end
  end

  // Raster counters: held at zero outside RUN, free-running inside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (!w_run) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (r_hCnt == H_LAST) begin
      r_hCnt <= '0;
      r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + VW'(1);
    end else begin
      r_hCnt <= r_hCnt + HW'(1);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // FIFO storage has no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= pix_in;
    end
  end

  // Registered pin outputs, one cycle behind the counters. On an empty-FIFO
  // de cycle the pixel is forced to black but de stays high so the
  // transmitter never sees a timing glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data    <= '0;
      out_de      <= 1'b0;
      out_hsync   <= SYNC_OFF;
      out_vsync   <= SYNC_OFF;
      frame_start <= 1'b0;
    end else if (w_run) begin
      out_data    <= w_pop ? r_mem[r_rdPtr] : '0;
      out_de      <= w_de;
      out_hsync   <= w_hsAct ? SYNC_ON : SYNC_OFF;
      out_vsync   <= w_vsAct ? SYNC_ON : SYNC_OFF;
      frame_start <= (r_hCnt == '0) && (r_vCnt == '0);
    end else begin
      out_data    <= '0;
      out_de      <= 1'b0;
      out_hsync   <= SYNC_OFF;
      out_vsync   <= SYNC_OFF;
      frame_start <= 1'b0;
    end
  end

  // Sticky underflow flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow <= 1'b0;
    end else if (w_run && w_de && w_empty) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule
